// File: rtl/rom_arb_pkg.sv
// Shared definitions for the two-port instruction ROM arbiter.
package rom_arb_pkg;

    // Port indices into the per-port request/response vectors
    localparam int PORT_FETCH = 0;
    localparam int PORT_LOAD  = 1;

    // Width of the port-1 starvation counter
    localparam int STARVE_W = 4;

    // Outcome of one cycle of arbitration
    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_FETCH = 2'd1,
        GRANT_LOAD  = 2'd2
    } grant_e;

    // Full 32-bit unsigned range check against the ROM size
    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input logic [31:0] limit);
        return (addr >= limit);
    endfunction

endpackage

// File: rtl/rom_resp_slot.sv
// One-entry response holding register: loads a ROM word on accept, keeps it
// stable until the consumer drains it. Load wins over drain so a same-cycle
// drain-and-refill produces no bubble.
module rom_resp_slot
    import rom_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_drain,
    input  logic [31:0] i_data,
    input  logic        i_err,
    output logic        o_full,
    output logic [31:0] o_data,
    output logic        o_err
);

    logic        r_full;
    logic [31:0] r_data;
    logic        r_err;

    // Slot occupancy, data and error flag update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= 32'h0000_0000;
            r_err  <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
            r_err  <= i_err;
        end else if (i_drain && r_full) begin
            r_full <= 1'b0;
        end else begin
            r_full <= r_full;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;
    assign o_err  = r_err;

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one combinational instruction ROM between the fetch port (0) and the
// constant-load port (1). Port 0 has fixed priority; a starvation counter
// forces a port-1 grant after STARVE_LIMIT consecutive losses.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter logic [31:0] ROM_BYTES    = 32'h0004_0000,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [31:0] resp_data0,
    output logic [31:0] resp_data1,
    output logic [1:0]  resp_err,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data
);

    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

    grant_e              w_grant;
    logic [1:0]          w_full;
    logic [1:0]          w_free;
    logic [1:0]          w_elig;
    logic [1:0]          w_load;
    logic [31:0]         w_rom_addr;
    logic [31:0]         w_load_data;
    logic                w_load_err;
    logic                w_err0;
    logic                w_err1;
    logic [31:0]         r_rom_addr;
    logic [STARVE_W-1:0] r_starve_cnt;

    // Eligibility (slot free or draining this cycle) and priority grant
    always_comb begin
        w_free  = ~w_full | (w_full & resp_ready);
        w_elig  = req_valid & w_free;
        w_grant = GRANT_NONE;
        case (w_elig)
            2'b01:   w_grant = GRANT_FETCH;
            2'b10:   w_grant = GRANT_LOAD;
            2'b11: begin
                if (r_starve_cnt == LIMIT_C) begin
                    w_grant = GRANT_LOAD;
                end else begin
                    w_grant = GRANT_FETCH;
                end
            end
            default: w_grant = GRANT_NONE;
        endcase
    end

    // ROM address mux, per-port load strobes and captured word/error
    always_comb begin
        w_load     = 2'b00;
        w_rom_addr = r_rom_addr;
        case (w_grant)
            GRANT_FETCH: begin
                w_load[PORT_FETCH] = 1'b1;
                w_rom_addr         = req_addr0;
            end
            GRANT_LOAD: begin
                w_load[PORT_LOAD] = 1'b1;
                w_rom_addr        = req_addr1;
            end
            default: begin
                w_load     = 2'b00;
                w_rom_addr = r_rom_addr;
            end
        endcase
        w_load_err = addr_out_of_range(w_rom_addr, ROM_BYTES);
        if (w_load_err) begin
            w_load_data = 32'h0000_0000;
        end else begin
            w_load_data = rom_data;
        end
    end

    // Remember the last driven ROM address so it holds when nobody wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_addr <= 32'h0000_0000;
        end else if (w_grant != GRANT_NONE) begin
            r_rom_addr <= w_rom_addr;
        end else begin
            r_rom_addr <= r_rom_addr;
        end
    end

    // Count consecutive cycles port 1 was eligible but lost to port 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= {STARVE_W{1'b0}};
        end else if (w_elig[PORT_LOAD] && (w_grant == GRANT_FETCH)) begin
            if (r_starve_cnt == LIMIT_C) begin
                r_starve_cnt <= r_starve_cnt;
            end else begin
                r_starve_cnt <= r_starve_cnt + {{(STARVE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            r_starve_cnt <= {STARVE_W{1'b0}};
        end
    end

    rom_resp_slot u_slot_fetch (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[PORT_FETCH]),
        .i_drain (resp_ready[PORT_FETCH]),
        .i_data  (w_load_data),
        .i_err   (w_load_err),
        .o_full  (w_full[PORT_FETCH]),
        .o_data  (resp_data0),
        .o_err   (w_err0)
    );

    rom_resp_slot u_slot_load (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[PORT_LOAD]),
        .i_drain (resp_ready[PORT_LOAD]),
        .i_data  (w_load_data),
        .i_err   (w_load_err),
        .o_full  (w_full[PORT_LOAD]),
        .o_data  (resp_data1),
        .o_err   (w_err1)
    );

    assign req_ready  = w_load;
    assign rom_addr   = w_rom_addr;
    assign resp_valid = w_full;
    assign resp_err   = {w_err1, w_err0};

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model of the
// arbitration rules (priority, wait count, one-deep response slots).
module tb_rom_port_arbiter;

    localparam logic [31:0] ROM_B = 32'h0000_0100;
    localparam int          LIM   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_data0;
    logic [31:0] resp_data1;
    logic [1:0]  resp_err;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic        m_full [2];
    logic [31:0] m_data [2];
    logic        m_err  [2];
    int          m_wait;
    logic [31:0] m_rom_addr;

    logic [1:0]  g_obs_ready;
    int          g_win;

    always #5 clk = ~clk;

    // Synthetic ROM contents
    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    rom_port_arbiter #(
        .ROM_BYTES    (ROM_B),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data0 (resp_data0),
        .resp_data1 (resp_data1),
        .resp_err   (resp_err),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_full[p] = 1'b0;
            m_data[p] = 32'h0;
            m_err[p]  = 1'b0;
        end
        m_wait     = 0;
        m_rom_addr = 32'h0;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance model
    task automatic step();
        logic [31:0] a [2];
        logic [1:0]  elig;
        logic [1:0]  exp_ready;
        logic [31:0] exp_addr;
        int          win;
        @(negedge clk);
        a[0] = req_addr0;
        a[1] = req_addr1;
        for (int p = 0; p < 2; p++)
            elig[p] = req_valid[p] && (!m_full[p] || resp_ready[p]);
        win = -1;
        if (elig == 2'b01)      win = 0;
        else if (elig == 2'b10) win = 1;
        else if (elig == 2'b11) win = (m_wait >= LIM) ? 1 : 0;
        exp_ready = (win == 0) ? 2'b01 : ((win == 1) ? 2'b10 : 2'b00);
        exp_addr  = (win < 0) ? m_rom_addr : a[win];
        chk("req_ready", {30'h0, req_ready}, {30'h0, exp_ready});
        chk("rom_addr", rom_addr, exp_addr);
        chk("resp_valid", {30'h0, resp_valid}, {30'h0, m_full[1], m_full[0]});
        if (m_full[0]) begin
            chk("resp_data0", resp_data0, m_data[0]);
            chk("resp_err0", {31'h0, resp_err[0]}, {31'h0, m_err[0]});
        end
        if (m_full[1]) begin
            chk("resp_data1", resp_data1, m_data[1]);
            chk("resp_err1", {31'h0, resp_err[1]}, {31'h0, m_err[1]});
        end
        g_obs_ready = req_ready;
        g_win       = win;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (win == p) begin
                    m_full[p] = 1'b1;
                    m_err[p]  = (a[p] >= ROM_B);
                    m_data[p] = m_err[p] ? 32'h0 : rom_fn(a[p]);
                end else if (m_full[p] && resp_ready[p]) begin
                    m_full[p] = 1'b0;
                end
            end
            if (elig[1] && win == 0) m_wait++;
            else m_wait = 0;
            if (win >= 0) m_rom_addr = a[win];
        end
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return {22'h0, 8'($urandom_range(0, 79)), 2'b00};
        return $urandom;
    endfunction

    initial begin
        logic [31:0] held1;
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_addr0  = 32'h0;
        req_addr1  = 32'h0;
        resp_ready = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        step();
        rst = 1'b0;

        // Reset values
        chk("rst_req_ready", {30'h0, req_ready}, 32'h0);
        chk("rst_resp_valid", {30'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {30'h0, resp_err}, 32'h0);
        chk("rst_data0", resp_data0, 32'h0);
        chk("rst_data1", resp_data1, 32'h0);
        chk("rst_rom_addr", rom_addr, 32'h0);

        // Single fetch
        req_valid  = 2'b01;
        req_addr0  = 32'h0000_0008;
        resp_ready = 2'b11;
        step();
        chk("fetch_ready", {30'h0, g_obs_ready}, 32'h1);
        req_valid = 2'b00;
        chk("fetch_valid", {30'h0, resp_valid}, 32'h1);
        chk("fetch_data", resp_data0, 32'hDEAD_BEEF);
        chk("fetch_err", {30'h0, resp_err}, 32'h0);
        step();

        // Contention: pattern 0,0,0,0,1 repeating
        req_valid = 2'b11;
        req_addr0 = 32'h0000_0010;
        req_addr1 = 32'h0000_0020;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("contention_grant", {30'h0, g_obs_ready}, (k % 5 == 4) ? 32'h2 : 32'h1);
        end

        // Backpressure on port 1 right after its response appears
        held1      = rom_fn(32'h0000_0020);
        resp_ready = 2'b01;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_p0_stream", {30'h0, g_obs_ready}, 32'h1);
            chk("bp_valid", {30'h0, resp_valid}, 32'h3);
            chk("bp_data1", resp_data1, held1);
        end
        resp_ready = 2'b11;
        req_valid  = 2'b00;
        step();
        step();

        // Out of range and last in-range word
        req_valid = 2'b10;
        req_addr1 = 32'h0000_0100;
        step();
        chk("oob_err", {31'h0, resp_err[1]}, 32'h1);
        chk("oob_data", resp_data1, 32'h0);
        req_addr1 = 32'h0000_00FC;
        step();
        req_valid = 2'b00;
        chk("inr_err", {31'h0, resp_err[1]}, 32'h0);
        chk("inr_data", resp_data1, rom_fn(32'h0000_00FC));
        step();

        // Back-to-back fetches, one response per cycle
        req_valid = 2'b01;
        for (int k = 0; k < 8; k++) begin
            req_addr0 = 32'h0000_0040 + 32'(4 * k);
            step();
            chk("b2b_valid", {31'h0, resp_valid[0]}, 32'h1);
            chk("b2b_data", resp_data0, rom_fn(32'h0000_0040 + 32'(4 * k)));
        end
        req_valid = 2'b00;
        step();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            step();
            if (g_win == 0 || !req_valid[0]) begin
                req_valid[0] = ($urandom_range(0, 3) != 0);
                req_addr0    = rnd_addr();
            end
            if (g_win == 1 || !req_valid[1]) begin
                req_valid[1] = ($urandom_range(0, 3) != 0);
                req_addr1    = rnd_addr();
            end
            resp_ready = 2'($urandom);
        end

        // Reset while responses are pending
        req_valid  = 2'b11;
        req_addr0  = 32'h0000_0030;
        req_addr1  = 32'h0000_0034;
        resp_ready = 2'b00;
        step();
        step();
        rst       = 1'b1;
        req_valid = 2'b00;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", {30'h0, resp_valid}, 32'h0);
        chk("mid_rst_rom_addr", rom_addr, 32'h0);
        chk("mid_rst_err", {30'h0, resp_err}, 32'h0);

        // Counter cleared: fresh contention pattern
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_rst_grant", {30'h0, g_obs_ready}, (k == 4) ? 32'h2 : 32'h1);
        end
        req_valid = 2'b00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
